commutation_sequencer: RTL and testbench
========================================

COMMUTATION_SEQUENCER -- requirements
Module: commutation_sequencer

Interface
REQ-001 The block SHALL have parameter DEAD_CYCLES, default 50, meaning the number of clk cycles all gates are held off between drive patterns (1 us at 50 MHz).
REQ-002 The block SHALL have parameter CNT_W, default 8, meaning the dead-time counter width; DEAD_CYCLES SHALL be at least 1 and below 2**CNT_W.
REQ-003 The block SHALL have clk, input, 1 bit: the single 50 MHz system clock; all logic is on its rising edge.
REQ-004 The block SHALL have rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have step_clk, input, 1 bit: the commutation step clock from the clock divider; each rising edge advances one step.
REQ-006 The block SHALL have enable, input, 1 bit: run request.
REQ-007 The block SHALL have dir, input, 1 bit: rotation direction; 1 = forward (index increments), 0 = reverse.
REQ-008 The block SHALL have hi, output, 3 bits: high-side gate drive for phases {C,B,A}.
REQ-009 The block SHALL have lo, output, 3 bits: low-side gate drive for phases {C,B,A}.
REQ-010 The block SHALL have step_idx, output, 3 bits: current commutation step, range 0..5.
REQ-011 The block SHALL have float_phase, output, 2 bits: the undriven phase (0=A, 1=B, 2=C) for BEMF sensing.
REQ-012 The block SHALL have step_pulse, output, 1 bit: a one-cycle strobe in the cycle step_idx changes.

Function
REQ-013 The block SHALL first pass step_clk through a two-flop synchronizer, then a rising-edge detector.
- A rising edge is registered in step_idx exactly 3 clk cycles after the first clk edge that samples step_clk high.
REQ-014 The step table SHALL be:
- 0: A-hi, B-lo.
- 1: A-hi, C-lo.
- 2: B-hi, C-lo.
- 3: B-hi, A-lo.
- 4: C-hi, A-lo.
- 5: C-hi, B-lo.
- float_phase SHALL be C, B, A, C, B, A for steps 0 to 5.
REQ-015 Index arithmetic SHALL wrap: forward 5 goes to 0; reverse 0 goes to 5.
- dir is sampled at the detected edge.
REQ-016 The FSM SHALL have the states IDLE, DEAD and DRIVE.
- IDLE: hi and lo are 0; step_idx is held.
- DEAD: hi and lo are 0; the counter loads DEAD_CYCLES-1 on entry and decrements to 0, then the FSM goes to DRIVE.
- DRIVE: hi and lo follow the table for step_idx.
REQ-017 IDLE SHALL go to DEAD when enable=1.
- Step edges in IDLE are ignored.
REQ-018 In DRIVE, a detected step edge SHALL update step_idx, pulse step_pulse, and enter DEAD in the same clk cycle.
- Gates are therefore off in the following cycle.
REQ-019 A step edge detected while in DEAD SHALL update step_idx, pulse step_pulse, and reload the counter.
REQ-020 enable=0 SHALL force IDLE on the next clk edge from any state; gates go to 0 in that same registered update.
REQ-021 All outputs SHALL be registered.
- No cycle SHALL have hi[i]=lo[i]=1 for any phase i.
- Any change of the non-zero gate pattern SHALL pass through at least DEAD_CYCLES consecutive all-off cycles.

Reset
REQ-022 While rst=1, the block SHALL set: state=IDLE, hi=0, lo=0, step_idx=0, float_phase=2, step_pulse=0, counter=0, synchronizer and edge flops=0.
REQ-023 Reset asserted mid-DRIVE or mid-DEAD SHALL take effect on the next clk edge and override every other input.

Configuration
REQ-024 Macro COMM_BRAKE_EN, when defined, SHALL add an input port brake (1 bit) and a BRAKE state.
- From DRIVE, brake=1 SHALL go to DEAD, then BRAKE.
- BRAKE: hi=0, lo=3'b111; step edges are ignored.
- brake=0 SHALL go from BRAKE to DEAD, then DRIVE at the held step_idx.
- enable=0 SHALL still force IDLE.
REQ-025 Without COMM_BRAKE_EN, there SHALL be no brake port and no BRAKE state, and behaviour SHALL be exactly REQ-013 to REQ-021.

Structure
REQ-026 Package comm_pkg SHALL hold:
- the FSM state encoding;
- the six-entry hi, lo and float_phase step tables;
- the phase encoding constants;
- the step count constant 6.
REQ-027 Sub-module step_edge_detect SHALL contain the two-flop synchronizer and the rising-edge detector, with ports clk, rst, in, rise.

Verification
REQ-028 Scenario: rst, then enable=1, dir=1, DEAD_CYCLES=50 -> 50 all-off cycles, then hi=001, lo=010.
REQ-029 Scenario: six step_clk rising edges forward -> step_idx 1,2,3,4,5,0, each followed by 50 all-off cycles, each with one step_pulse.
REQ-030 Scenario: dir=0 at step_idx=0, one edge -> step_idx=5, hi=100, lo=010 after dead time.
REQ-031 Scenario: step edge 10 cycles into DEAD -> step_idx advances and the dead count restarts, so the all-off interval totals 60 cycles.
REQ-032 Scenario: enable drops mid-DRIVE -> hi=lo=0 next cycle and step_idx held; rst mid-DEAD -> all reset values next cycle.
REQ-033 Scenario (with COMM_BRAKE_EN): brake=1 in DRIVE -> 50 off cycles then lo=111, hi=000; release -> 50 off cycles then the previous step pattern.

Source files
------------

// File: rtl/comm_pkg.sv
// Shared types and step tables for the six-step BLDC commutation sequencer.
// Optional braking support is enabled by defining COMM_BRAKE_EN.
package comm_pkg;

    localparam int unsigned NUM_STEPS = 6;
    localparam int unsigned STEP_W    = 3;
    localparam int unsigned PHASES    = 3;
    localparam int unsigned PHASE_W   = 2;

    localparam logic [PHASE_W-1:0] PHASE_A = 2'd0;
    localparam logic [PHASE_W-1:0] PHASE_B = 2'd1;
    localparam logic [PHASE_W-1:0] PHASE_C = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DEAD  = 2'd1,
        DRIVE = 2'd2
`ifdef COMM_BRAKE_EN
        ,
        BRAKE = 2'd3
`endif
    } comm_state_t;

    // Gate vectors are {C,B,A}; entry 0 sits in the least significant slot.
    localparam logic [NUM_STEPS-1:0][PHASES-1:0] HI_TABLE = {
        3'b100, 3'b100, 3'b010, 3'b010, 3'b001, 3'b001
    };
    localparam logic [NUM_STEPS-1:0][PHASES-1:0] LO_TABLE = {
        3'b010, 3'b001, 3'b001, 3'b100, 3'b100, 3'b010
    };
    localparam logic [NUM_STEPS-1:0][PHASE_W-1:0] FLOAT_TABLE = {
        PHASE_A, PHASE_B, PHASE_C, PHASE_A, PHASE_B, PHASE_C
    };

    // Out-of-range indices decode to all-off so a corrupted index never drives gates.
    function automatic logic [PHASES-1:0] step_hi(input logic [STEP_W-1:0] idx);
        if (idx < STEP_W'(NUM_STEPS)) begin
            return HI_TABLE[idx];
        end
        return '0;
    endfunction

    function automatic logic [PHASES-1:0] step_lo(input logic [STEP_W-1:0] idx);
        if (idx < STEP_W'(NUM_STEPS)) begin
            return LO_TABLE[idx];
        end
        return '0;
    endfunction

    function automatic logic [PHASE_W-1:0] step_float(input logic [STEP_W-1:0] idx);
        if (idx < STEP_W'(NUM_STEPS)) begin
            return FLOAT_TABLE[idx];
        end
        return PHASE_C;
    endfunction

    // Modulo-6 step arithmetic in either direction.
    function automatic logic [STEP_W-1:0] step_advance(input logic [STEP_W-1:0] idx,
                                                       input logic fwd);
        if (fwd) begin
            if (idx >= STEP_W'(NUM_STEPS - 1)) begin
                return '0;
            end
            return idx + STEP_W'(1);
        end
        if ((idx == '0) || (idx >= STEP_W'(NUM_STEPS))) begin
            return STEP_W'(NUM_STEPS - 1);
        end
        return idx - STEP_W'(1);
    endfunction

endpackage

// File: rtl/step_edge_detect.sv
// Two-flop synchronizer followed by a registered rising-edge detector.
module step_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic rise
);

    logic sync1;
    logic sync2;
    logic prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
            rise  <= 1'b0;
        end else begin
            sync1 <= in;
            sync2 <= sync1;
            prev  <= sync2;
            rise  <= sync2 & ~prev;
        end
    end

endmodule

// File: rtl/commutation_sequencer.sv
// Six-step trapezoidal commutation sequencer with dead-time insertion.
// Define COMM_BRAKE_EN to add the brake input and the low-side BRAKE state.
module commutation_sequencer
    import comm_pkg::*;
#(
    parameter int unsigned DEAD_CYCLES = 50,
    parameter int unsigned CNT_W       = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               step_clk,
    input  logic               enable,
    input  logic               dir,
`ifdef COMM_BRAKE_EN
    input  logic               brake,
`endif
    output logic [PHASES-1:0]  hi,
    output logic [PHASES-1:0]  lo,
    output logic [STEP_W-1:0]  step_idx,
    output logic [PHASE_W-1:0] float_phase,
    output logic               step_pulse
);

    localparam logic [CNT_W-1:0] DEAD_LOAD = CNT_W'(DEAD_CYCLES - 1);

    comm_state_t        state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [STEP_W-1:0]  idx_n;
    logic [PHASES-1:0]  hi_n, lo_n;
    logic [PHASE_W-1:0] float_n;
    logic               pulse_n;
    logic               step_rise;

    step_edge_detect u_step_edge (
        .clk  (clk),
        .rst  (rst),
        .in   (step_clk),
        .rise (step_rise)
    );

    // State, counter and every output are registered together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            step_idx    <= '0;
            hi          <= '0;
            lo          <= '0;
            float_phase <= PHASE_C;
            step_pulse  <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            step_idx    <= idx_n;
            hi          <= hi_n;
            lo          <= lo_n;
            float_phase <= float_n;
            step_pulse  <= pulse_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = step_idx;
        pulse_n = 1'b0;
        hi_n    = '0;
        lo_n    = '0;

        unique case (state)
            IDLE: begin
                if (enable) begin
                    state_n = DEAD;
                    cnt_n   = DEAD_LOAD;
                end
            end
            DEAD: begin
                // A new step restarts the full dead interval.
                if (step_rise) begin
                    idx_n   = step_advance(step_idx, dir);
                    pulse_n = 1'b1;
                    cnt_n   = DEAD_LOAD;
                end else if (cnt == '0) begin
`ifdef COMM_BRAKE_EN
                    state_n = brake ? BRAKE : DRIVE;
`else
                    state_n = DRIVE;
`endif
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            DRIVE: begin
`ifdef COMM_BRAKE_EN
                if (brake) begin
                    state_n = DEAD;
                    cnt_n   = DEAD_LOAD;
                end else
`endif
                if (step_rise) begin
                    idx_n   = step_advance(step_idx, dir);
                    pulse_n = 1'b1;
                    state_n = DEAD;
                    cnt_n   = DEAD_LOAD;
                end
            end
`ifdef COMM_BRAKE_EN
            BRAKE: begin
                if (!brake) begin
                    state_n = DEAD;
                    cnt_n   = DEAD_LOAD;
                end
            end
`endif
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase

        // Disable wins over everything, including a coincident step edge.
        if (!enable) begin
            state_n = IDLE;
            cnt_n   = '0;
            idx_n   = step_idx;
            pulse_n = 1'b0;
        end

        // Gates are decoded from the next state so they change with the state register.
        unique case (state_n)
            DRIVE: begin
                hi_n = step_hi(idx_n);
                lo_n = step_lo(idx_n);
            end
`ifdef COMM_BRAKE_EN
            BRAKE: begin
                hi_n = '0;
                lo_n = '1;
            end
`endif
            default: begin
                hi_n = '0;
                lo_n = '0;
            end
        endcase

        float_n = step_float(idx_n);
    end

endmodule

// File: tb/tb_commutation_sequencer.sv
// Directed self-checking bench for commutation_sequencer (DEAD_CYCLES = 50).
module tb_commutation_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       step_clk;
    logic       enable;
    logic       dir;
`ifdef COMM_BRAKE_EN
    logic       brake;
`endif
    logic [2:0] hi;
    logic [2:0] lo;
    logic [2:0] step_idx;
    logic [1:0] float_phase;
    logic       step_pulse;

    int checks = 0;
    int errors = 0;

    // Hand-written expected patterns for steps 0..5, gate vectors {C,B,A}.
    logic [2:0] exp_hi    [6] = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100};
    logic [2:0] exp_lo    [6] = '{3'b010, 3'b100, 3'b100, 3'b001, 3'b001, 3'b010};
    logic [1:0] exp_float [6] = '{2'd2, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0};

    commutation_sequencer #(
        .DEAD_CYCLES (50),
        .CNT_W       (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .step_clk    (step_clk),
        .enable      (enable),
        .dir         (dir),
`ifdef COMM_BRAKE_EN
        .brake       (brake),
`endif
        .hi          (hi),
        .lo          (lo),
        .step_idx    (step_idx),
        .float_phase (float_phase),
        .step_pulse  (step_pulse)
    );

    always #10 clk = ~clk;

    // Shoot-through must never occur on any phase.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            checks++;
            assert ((hi & lo) === 3'b000) else begin
                errors++;
                $error("FAIL shoot_through observed hi=%b lo=%b expected no overlap", hi, lo);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts consecutive all-off observations starting now; optionally raises step_clk.
    task automatic off_run(input int raise_at, output int n, output int pulses);
        n      = 0;
        pulses = 0;
        while ((hi === 3'b000) && (lo === 3'b000) && (n < 300)) begin
            n++;
            pulses += (step_pulse === 1'b1) ? 1 : 0;
            if (n == raise_at) step_clk = 1'b1;
            tick();
        end
    endtask

    task automatic check_pattern(input string tag, input int s);
        check({tag, "_idx"},   32'(step_idx),    32'(s));
        check({tag, "_hi"},    32'(hi),          32'(exp_hi[s]));
        check({tag, "_lo"},    32'(lo),          32'(exp_lo[s]));
        check({tag, "_float"}, 32'(float_phase), 32'(exp_float[s]));
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_hi"},    32'(hi),          32'd0);
        check({tag, "_lo"},    32'(lo),          32'd0);
        check({tag, "_idx"},   32'(step_idx),    32'd0);
        check({tag, "_float"}, 32'(float_phase), 32'd2);
        check({tag, "_pulse"}, 32'(step_pulse),  32'd0);
    endtask

    // One step edge from DRIVE: 3-cycle latency, pulse, 50 off cycles, new pattern.
    task automatic do_step(input int prev_idx, input int new_idx, input string tag);
        int n;
        int p;
        step_clk = 1'b1;
        repeat (3) tick();
        check({tag, "_lat_idx"},   32'(step_idx),   32'(prev_idx));
        check({tag, "_lat_pulse"}, 32'(step_pulse), 32'd0);
        tick();
        check({tag, "_upd_idx"},   32'(step_idx),   32'(new_idx));
        check({tag, "_upd_pulse"}, 32'(step_pulse), 32'd1);
        step_clk = 1'b0;
        off_run(-1, n, p);
        check({tag, "_dead"},   32'(n), 32'd50);
        check({tag, "_pulses"}, 32'(p), 32'd1);
        check_pattern(tag, new_idx);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int p;

        rst      = 1'b1;
        step_clk = 1'b0;
        enable   = 1'b0;
        dir      = 1'b1;
`ifdef COMM_BRAKE_EN
        brake    = 1'b0;
`endif
        repeat (3) tick();
        check_reset("reset");

        // Startup: 50 off cycles then step 0.
        rst    = 1'b0;
        enable = 1'b1;
        tick();
        off_run(-1, n, p);
        check("start_dead", 32'(n), 32'd50);
        check("start_pulses", 32'(p), 32'd0);
        check_pattern("start", 0);

        // Six forward steps with wrap 5 -> 0.
        do_step(0, 1, "fwd1");
        do_step(1, 2, "fwd2");
        do_step(2, 3, "fwd3");
        do_step(3, 4, "fwd4");
        do_step(4, 5, "fwd5");
        do_step(5, 0, "fwd6");

        // Reverse wrap 0 -> 5.
        dir = 1'b0;
        do_step(0, 5, "rev");

        // Second edge 10 cycles into DEAD restarts the dead interval.
        dir      = 1'b1;
        step_clk = 1'b1;
        repeat (4) tick();
        check("redead_first_idx", 32'(step_idx), 32'd0);
        step_clk = 1'b0;
        off_run(7, n, p);
        step_clk = 1'b0;
        check("redead_total", 32'(n), 32'd60);
        check("redead_pulses", 32'(p), 32'd2);
        check_pattern("redead", 1);

        // Enable drop mid-DRIVE: gates off next cycle, index held, edges ignored.
        repeat (5) tick();
        enable = 1'b0;
        tick();
        check("dis_hi", 32'(hi), 32'd0);
        check("dis_lo", 32'(lo), 32'd0);
        check("dis_idx", 32'(step_idx), 32'd1);
        check("dis_float", 32'(float_phase), 32'd1);
        step_clk = 1'b1;
        repeat (6) tick();
        check("idle_edge_idx", 32'(step_idx), 32'd1);
        check("idle_edge_hi", 32'(hi), 32'd0);
        step_clk = 1'b0;
        repeat (4) tick();

        // Re-enable resumes at the held step after a full dead interval.
        enable = 1'b1;
        tick();
        off_run(-1, n, p);
        check("reen_dead", 32'(n), 32'd50);
        check_pattern("reen", 1);

        // Reset in the middle of DEAD.
        step_clk = 1'b1;
        repeat (4) tick();
        check("pre_rst_idx", 32'(step_idx), 32'd2);
        step_clk = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        check_reset("mid_rst");
        tick();
        rst = 1'b0;
        tick();
        off_run(-1, n, p);
        check("post_rst_dead", 32'(n), 32'd50);
        check_pattern("post_rst", 0);

`ifdef COMM_BRAKE_EN
        // Brake: dead time, low sides on, release, dead time, previous pattern.
        brake = 1'b1;
        tick();
        off_run(-1, n, p);
        check("brake_dead", 32'(n), 32'd50);
        check("brake_hi", 32'(hi), 32'd0);
        check("brake_lo", 32'(lo), 32'b111);
        step_clk = 1'b1;
        repeat (6) tick();
        step_clk = 1'b0;
        check("brake_edge_idx", 32'(step_idx), 32'd0);
        check("brake_edge_lo", 32'(lo), 32'b111);
        brake = 1'b0;
        tick();
        off_run(-1, n, p);
        check("unbrake_dead", 32'(n), 32'd50);
        check_pattern("unbrake", 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
